// File: rtl/cache_pkg.sv
// cache_pkg: shared types and geometry constants for the direct-mapped cache controller
//   LINE_BYTES : bytes per cache line (two DATA_W words)
//   TAG_W      : tag width at the default 16-bit address / 8-line geometry
//   INDEX_W    : line-index width at the default 8-line geometry
package cache_pkg;
   localparam int LINE_BYTES = 4;
   localparam int TAG_W      = 11;
   localparam int INDEX_W    = 3;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } instr_type_e;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WB0,
      WB1,
      FILL0,
      FILL1,
      FILL2
   } state_e;
endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: tag/valid/dirty/data arrays, one combinational read port, one write port
//   clk, rst_n      : clock, async active-low reset (clears valid and dirty only)
//   rd_idx          : read line index -> rd_valid, rd_dirty, rd_tag, rd_data
//   we, wr_idx      : write enable and line index; a write always marks the line valid
//   wr_dirty        : dirty bit to store with the line
//   wr_tag, wr_data : tag and full line data {high word, low word}
module cache_line_store
   import cache_pkg::*;
#(
   parameter int NUM_LINES = 8,
   parameter int IW        = INDEX_W,
   parameter int TW        = TAG_W,
   parameter int LINE_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IW-1:0]     rd_idx,
   output logic              rd_valid,
   output logic              rd_dirty,
   output logic [TW-1:0]     rd_tag,
   output logic [LINE_W-1:0] rd_data,
   input  logic              we,
   input  logic [IW-1:0]     wr_idx,
   input  logic              wr_dirty,
   input  logic [TW-1:0]     wr_tag,
   input  logic [LINE_W-1:0] wr_data
);
   logic [NUM_LINES-1:0] valid_q, dirty_q;
   logic [TW-1:0]        tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (we) begin
         valid_q[wr_idx] <= 1'b1;
         dirty_q[wr_idx] <= wr_dirty;
      end
   end

   // Tag and data need no reset: a cleared valid bit masks them.
   always_ff @(posedge clk) begin
      if (we) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_dirty = dirty_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[rd_idx];
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped write-back cache controller, 2-word lines, single request in flight
//   clk, rst_n                         : clock, async active-low reset
//   req_valid/req_ready                : CPU request handshake (ready only in IDLE)
//   req_write, req_addr, req_wdata     : operation, byte address, store data
//   resp_valid, resp_rdata             : one-cycle completion pulse and load data
//   resp_err                           : one-cycle pulse for a rejected odd address
//   mem_addr, mem_wdata, mem_wren      : backing-RAM request (zero when unused)
//   mem_rdata                          : backing-RAM read data, one cycle after mem_addr
//   hit_count, miss_count              : saturating statistics, only with CACHE_CTRL_STATS_EN
module cache_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int NUM_LINES = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_CTRL_STATS_EN
   ,
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count
`endif
);
   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_BITS = ADDR_W - IDX_W - OFF_W;

   state_e              state_q, state_d;
   logic [ADDR_W-1:1]   addr_q, addr_d;
   instr_type_e         op_q, op_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   fill_lo_q, fill_lo_d;
   logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_err_q, resp_err_d;
   logic                replay_q, replay_d;

   logic [IDX_W-1:0]    idx;
   logic [TAG_BITS-1:0] tag;
   logic                sel, accept, lookup, hit;
   logic [DATA_W-1:0]   lo, hi, hit_word, fill_word;

   logic                rd_valid, rd_dirty, st_we, st_dirty;
   logic [TAG_BITS-1:0] rd_tag;
   logic [2*DATA_W-1:0] rd_data, st_wdata;

   assign idx       = addr_q[IDX_W+OFF_W-1:OFF_W];
   assign tag       = addr_q[ADDR_W-1:IDX_W+OFF_W];
   assign sel       = addr_q[1];
   assign accept    = (state_q == IDLE) && req_valid;
   assign lookup    = (state_q == LOOKUP);
   assign hit       = rd_valid && (rd_tag == tag);
   assign lo        = rd_data[DATA_W-1:0];
   assign hi        = rd_data[2*DATA_W-1:DATA_W];
   assign hit_word  = sel ? hi : lo;
   assign fill_word = sel ? mem_rdata : fill_lo_q;

   cache_line_store #(
      .NUM_LINES(NUM_LINES),
      .IW       (IDX_W),
      .TW       (TAG_BITS),
      .LINE_W   (2*DATA_W)
   ) u_store (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_idx  (idx),
      .rd_valid(rd_valid),
      .rd_dirty(rd_dirty),
      .rd_tag  (rd_tag),
      .rd_data (rd_data),
      .we      (st_we),
      .wr_idx  (idx),
      .wr_dirty(st_dirty),
      .wr_tag  (tag),
      .wr_data (st_wdata)
   );

   // Store writes: a write hit (first or replay LOOKUP) merges one half and
   // marks the line dirty; FILL2 installs the fetched line clean.
   assign st_we    = (lookup && hit && op_q == WRITE) || (state_q == FILL2);
   assign st_dirty = (state_q != FILL2);
   assign st_wdata = (state_q == FILL2) ? {mem_rdata, fill_lo_q} :
                     sel ? {wdata_q, lo} : {hi, wdata_q};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid && !req_addr[0]) state_d = LOOKUP;
         LOOKUP:  state_d = hit ? IDLE : (rd_valid && rd_dirty) ? WB0 : FILL0;
         WB0:     state_d = WB1;
         WB1:     state_d = FILL0;
         FILL0:   state_d = FILL1;
         FILL1:   state_d = FILL2;
         FILL2:   state_d = LOOKUP;
         default: state_d = IDLE;
      endcase
   end

   // The response of a miss is issued as the line is installed (the high
   // word is still on mem_rdata), so the replay LOOKUP only commits a
   // pending store and must not respond a second time.
   assign addr_d       = accept ? req_addr[ADDR_W-1:1] : addr_q;
   assign op_d         = accept ? instr_type_e'(req_write) : op_q;
   assign wdata_d      = accept ? req_wdata : wdata_q;
   assign fill_lo_d    = (state_q == FILL1) ? mem_rdata : fill_lo_q;
   assign replay_d     = (state_q == FILL2);
   assign resp_err_d   = accept && req_addr[0];
   assign resp_valid_d = (lookup && hit && !replay_q) || (state_q == FILL2);
   assign resp_rdata_d = (resp_valid_d && op_q == READ) ? (lookup ? hit_word : fill_word) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         op_q         <= READ;
         wdata_q      <= '0;
         fill_lo_q    <= '0;
         resp_rdata_q <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         replay_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         op_q         <= op_d;
         wdata_q      <= wdata_d;
         fill_lo_q    <= fill_lo_d;
         resp_rdata_q <= resp_rdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         replay_q     <= replay_d;
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         WB0: begin
            mem_addr  = {rd_tag, idx, OFF_W'(0)};
            mem_wdata = lo;
         end
         WB1: begin
            mem_addr  = {rd_tag, idx, OFF_W'(2)};
            mem_wdata = hi;
         end
         FILL0:   mem_addr = {tag, idx, OFF_W'(0)};
         FILL1:   mem_addr = {tag, idx, OFF_W'(2)};
         default: mem_addr = '0;
      endcase
   end

   assign mem_wren   = (state_q == WB0) || (state_q == WB1);
   assign req_ready  = (state_q == IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

`ifdef CACHE_CTRL_STATS_EN
   logic [15:0] hit_q, miss_q;

   // The replay LOOKUP always hits and is excluded from both counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         if (lookup && hit && !replay_q && hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
         if (lookup && !hit && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed self-checking bench for cache_ctrl with a 1-cycle registered RAM model
module tb_cache_ctrl;
   logic        clk, rst_n, req_valid, req_write, req_ready;
   logic [15:0] req_addr, req_wdata, mem_rdata;
   logic        resp_valid, resp_err, mem_wren;
   logic [15:0] resp_rdata, mem_addr, mem_wdata;
`ifdef CACHE_CTRL_STATS_EN
   logic [15:0] hit_count, miss_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] ram [0:255];
   logic [15:0] addr_t  [0:31];
   logic [15:0] wdata_t [0:31];
   logic        wren_t  [0:31];
   logic        ready_t [0:31];
   int          lat, wren_cnt;
   logic [15:0] rdata;
   logic        err_seen, valid_seen, resp_after;

   cache_ctrl #(.ADDR_W(16), .DATA_W(16), .NUM_LINES(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .resp_err  (resp_err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wren  (mem_wren),
      .mem_rdata (mem_rdata)
`ifdef CACHE_CTRL_STATS_EN
      ,
      .hit_count (hit_count),
      .miss_count(miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word-addressed backing RAM, read data registered one cycle after the address.
   always @(posedge clk) begin
      if (mem_wren) ram[mem_addr[8:1]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[8:1]];
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Issue one request; cycle n=1 is the cycle after the accepting edge.
   // hold keeps req_valid high with an odd address while the controller is busy.
   task automatic do_req(input logic wr, input logic [15:0] a, input logic [15:0] d, input bit hold);
      lat = 99; rdata = '0; err_seen = 0; valid_seen = 0; wren_cnt = 0;
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      @(posedge clk);
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 1) begin
            if (hold) req_addr = 16'h0001;
            else req_valid = 1'b0;
         end
         addr_t[n] = mem_addr; wdata_t[n] = mem_wdata; wren_t[n] = mem_wren; ready_t[n] = req_ready;
         if (mem_wren) wren_cnt++;
         if (resp_valid || resp_err) begin
            lat = n; rdata = resp_rdata; err_seen = resp_err; valid_seen = resp_valid;
            break;
         end
      end
      req_valid = 1'b0;
      @(negedge clk);
      resp_after = resp_valid | resp_err;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
      checks++; if (resp_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h want 0000", resp_rdata); end
      checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b want 0", mem_wren); end
      checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0000", mem_addr); end
      checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0000", mem_wdata); end
   endtask

   task automatic test_read_miss();
      do_req(1'b0, 16'h0004, 16'h0, 1'b0);
      checks++; if (lat !== 5) begin errors++; $display("FAIL miss_latency got %0d want 5", lat); end
      checks++; if (rdata !== 16'hA002) begin errors++; $display("FAIL miss_rdata got %h want a002", rdata); end
      checks++; if (addr_t[2] !== 16'h0004) begin errors++; $display("FAIL fill0_addr got %h want 0004", addr_t[2]); end
      checks++; if (addr_t[3] !== 16'h0006) begin errors++; $display("FAIL fill1_addr got %h want 0006", addr_t[3]); end
      checks++; if (wren_cnt !== 0) begin errors++; $display("FAIL clean_miss_wren got %0d want 0", wren_cnt); end
      checks++; if (resp_after !== 1'b0) begin errors++; $display("FAIL miss_pulse_width got %b want 0", resp_after); end
   endtask

   task automatic test_write_hit();
      do_req(1'b1, 16'h0006, 16'h0100, 1'b0);
      checks++; if (lat !== 2) begin errors++; $display("FAIL write_hit_latency got %0d want 2", lat); end
      checks++; if (wren_cnt !== 0) begin errors++; $display("FAIL write_hit_wren got %0d want 0", wren_cnt); end
      do_req(1'b0, 16'h0006, 16'h0, 1'b0);
      checks++; if (lat !== 2) begin errors++; $display("FAIL read_hit_latency got %0d want 2", lat); end
      checks++; if (rdata !== 16'h0100) begin errors++; $display("FAIL read_hit_hi got %h want 0100", rdata); end
      do_req(1'b0, 16'h0004, 16'h0, 1'b0);
      checks++; if (rdata !== 16'hA002) begin errors++; $display("FAIL read_hit_lo got %h want a002", rdata); end
      checks++; if (resp_after !== 1'b0) begin errors++; $display("FAIL hit_pulse_width got %b want 0", resp_after); end
   endtask

   task automatic test_dirty_evict();
      do_req(1'b0, 16'h0024, 16'h0, 1'b0);
      checks++; if (lat !== 7) begin errors++; $display("FAIL dirty_latency got %0d want 7", lat); end
      checks++; if (wren_t[2] !== 1'b1 || addr_t[2] !== 16'h0004 || wdata_t[2] !== 16'hA002) begin errors++; $display("FAIL wb0 got wren %b addr %h data %h want 1 0004 a002", wren_t[2], addr_t[2], wdata_t[2]); end
      checks++; if (wren_t[3] !== 1'b1 || addr_t[3] !== 16'h0006 || wdata_t[3] !== 16'h0100) begin errors++; $display("FAIL wb1 got wren %b addr %h data %h want 1 0006 0100", wren_t[3], addr_t[3], wdata_t[3]); end
      checks++; if (wren_t[4] !== 1'b0 || addr_t[4] !== 16'h0024) begin errors++; $display("FAIL evict_fill0 got wren %b addr %h want 0 0024", wren_t[4], addr_t[4]); end
      checks++; if (addr_t[5] !== 16'h0026) begin errors++; $display("FAIL evict_fill1 got %h want 0026", addr_t[5]); end
      checks++; if (wren_cnt !== 2) begin errors++; $display("FAIL evict_wren_count got %0d want 2", wren_cnt); end
      checks++; if (rdata !== 16'hA012) begin errors++; $display("FAIL evict_rdata got %h want a012", rdata); end
      do_req(1'b0, 16'h0006, 16'h0, 1'b0);
      checks++; if (lat !== 5 || rdata !== 16'h0100) begin errors++; $display("FAIL written_back got lat %0d data %h want 5 0100", lat, rdata); end
   endtask

   task automatic test_misaligned();
      do_req(1'b0, 16'h0003, 16'h0, 1'b0);
      checks++; if (lat !== 1 || err_seen !== 1'b1) begin errors++; $display("FAIL err_pulse got lat %0d err %b want 1 1", lat, err_seen); end
      checks++; if (valid_seen !== 1'b0) begin errors++; $display("FAIL err_no_valid got %b want 0", valid_seen); end
      checks++; if (ready_t[1] !== 1'b1) begin errors++; $display("FAIL err_ready got %b want 1", ready_t[1]); end
      checks++; if (wren_t[1] !== 1'b0 || addr_t[1] !== 16'h0) begin errors++; $display("FAIL err_mem_idle got wren %b addr %h want 0 0000", wren_t[1], addr_t[1]); end
      checks++; if (resp_after !== 1'b0) begin errors++; $display("FAIL err_pulse_width got %b want 0", resp_after); end
   endtask

   task automatic test_write_miss();
      do_req(1'b1, 16'h0040, 16'hBEEF, 1'b0);
      checks++; if (lat !== 5) begin errors++; $display("FAIL write_miss_latency got %0d want 5", lat); end
      do_req(1'b0, 16'h0040, 16'h0, 1'b0);
      checks++; if (lat !== 2 || rdata !== 16'hBEEF) begin errors++; $display("FAIL write_miss_merge got lat %0d data %h want 2 beef", lat, rdata); end
      do_req(1'b0, 16'h0042, 16'h0, 1'b0);
      checks++; if (lat !== 2 || rdata !== 16'hA021) begin errors++; $display("FAIL write_miss_other got lat %0d data %h want 2 a021", lat, rdata); end
   endtask

   task automatic test_busy_ignore();
      do_req(1'b0, 16'h000C, 16'h0, 1'b1);
      checks++; if (lat !== 5 || err_seen !== 1'b0 || rdata !== 16'hA006) begin errors++; $display("FAIL busy_ignore got lat %0d err %b data %h want 5 0 a006", lat, err_seen, rdata); end
      checks++; if (ready_t[2] !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", ready_t[2]); end
   endtask

   task automatic test_reset_mid_fill();
      logic seen;
      seen = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0008;
      @(posedge clk);
      for (int n = 1; n <= 3; n++) begin
         @(negedge clk);
         if (n == 1) req_valid = 1'b0;
      end
      checks++; if (mem_addr !== 16'h000A) begin errors++; $display("FAIL midfill_in_fill1 got %h want 000a", mem_addr); end
      rst_n = 1'b0;
      #1;
      checks++; if (mem_wren !== 1'b0 || mem_addr !== 16'h0) begin errors++; $display("FAIL midfill_mem got wren %b addr %h want 0 0000", mem_wren, mem_addr); end
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      rst_n = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midfill_no_resp got %b want 0", seen); end
      do_req(1'b0, 16'h0008, 16'h0, 1'b0);
      checks++; if (lat !== 5 || rdata !== 16'hA004) begin errors++; $display("FAIL midfill_remiss got lat %0d data %h want 5 a004", lat, rdata); end
      do_req(1'b0, 16'h0004, 16'h0, 1'b0);
      checks++; if (lat !== 5) begin errors++; $display("FAIL reset_invalidates got lat %0d want 5", lat); end
   endtask

`ifdef CACHE_CTRL_STATS_EN
   task automatic test_stats();
      do_reset();
      @(negedge clk);
      checks++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin errors++; $display("FAIL stats_reset got %h %h want 0000 0000", hit_count, miss_count); end
      do_req(1'b0, 16'h0004, 16'h0, 1'b0);
      do_req(1'b0, 16'h0004, 16'h0, 1'b0);
      checks++; if (miss_count !== 16'h1) begin errors++; $display("FAIL stats_miss got %h want 0001", miss_count); end
      checks++; if (hit_count !== 16'h1) begin errors++; $display("FAIL stats_hit got %h want 0001", hit_count); end
   endtask
`endif

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 16'hA000 + 16'(i);
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      test_reset();
      test_read_miss();
      test_write_hit();
      test_dirty_evict();
      test_misaligned();
      test_write_miss();
      test_busy_ignore();
      test_reset_mid_fill();
`ifdef CACHE_CTRL_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning CPU/memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning word width.
REQ-003 SHALL have parameter NUM_LINES, default 8, meaning direct-mapped line count (power of 2).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  CPU request present.
REQ-007 req_ready  output  1  controller accepts request this cycle.
REQ-008 req_write  input  1  0 = READ, 1 = WRITE.
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  DATA_W  store data.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  DATA_W  load data, valid with resp_valid on READ.
REQ-013 resp_err  output  1  one-cycle pulse, misaligned request rejected.
REQ-014 mem_addr  output  ADDR_W  backing-RAM byte address.
REQ-015 mem_wdata  output  DATA_W  backing-RAM write data.
REQ-016 mem_wren  output  1  backing-RAM write enable.
REQ-017 mem_rdata  input  DATA_W  backing-RAM read data, 1-cycle registered latency.

Function
REQ-018 Line = 4 bytes (two words); index = addr[4:2], tag = addr[15:5] (11 bits), word select = addr[1]; addr[1]=0 low half, 1 high half.
REQ-019 States: IDLE, LOOKUP, WB0, WB1, FILL0, FILL1, FILL2; req_ready SHALL be high only in IDLE.
REQ-020 IDLE: on req_valid&&req_ready, capture addr/op/wdata; addr[0]=1 -> resp_err pulse next cycle, stay IDLE, no state change; else -> LOOKUP.
REQ-021 LOOKUP hit (valid && tag match): READ drives resp_rdata with the selected half; WRITE updates the selected half and sets dirty; resp_valid pulses next cycle and state returns to IDLE (hit latency 2 cycles from accept).
REQ-022 LOOKUP miss, victim valid && dirty -> WB0; otherwise -> FILL0.
REQ-023 WB0: mem_wren=1, mem_addr={victim_tag,index,2'b00}, mem_wdata=low word; WB1: same base+2, high word; -> FILL0.
REQ-024 FILL0: mem_addr=base, mem_wren=0; FILL1: mem_addr=base+2, capture mem_rdata as low word; FILL2: capture high word, install line with valid=1, dirty=0, new tag; -> LOOKUP (replay, guaranteed hit).
REQ-025 Miss latency: clean = 5 cycles, dirty = 7 cycles from accept to resp_valid.
REQ-026 mem_wren SHALL be high only in WB0/WB1; mem_addr/mem_wdata are don't-care when unused but SHALL be driven 0 in IDLE.
REQ-027 Requests arriving while req_ready=0 SHALL be ignored (CPU holds them); at most one request in flight.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, clear all valid and dirty bits, and drive req_ready=1 (after release), resp_valid=0, resp_err=0, resp_rdata=0, mem_wren=0, mem_addr=0, mem_wdata=0.
REQ-029 Reset mid-WB/FILL SHALL abandon the transaction with no response; data array contents need not be cleared.

Configuration
REQ-030 With CACHE_CTRL_STATS_EN defined, SHALL add outputs hit_count and miss_count (16 bits each, saturating at 0xFFFF, reset 0); hit counted on first LOOKUP hit, miss on first LOOKUP miss, replay LOOKUP not counted.
REQ-031 Without CACHE_CTRL_STATS_EN, those ports and counters SHALL be absent.

Structure
REQ-032 Package cache_pkg SHALL hold the INSTR_TYPE enum (READ, WRITE), the state enum, and constants LINE_BYTES=4, TAG_W=11, INDEX_W=3.
REQ-033 Tag/valid/dirty/data arrays SHALL live in a sub-module cache_line_store (single read, single write port, write on rising edge).

Verification
REQ-034 Reset, READ 0x0004 -> miss, FILL reads 0x0004/0x0006 from RAM, resp_valid 5 cycles after accept with RAM[0x0004].
REQ-035 WRITE 0x0006 data 0x0100 after line fill -> hit, resp_valid 2 cycles after accept; READ 0x0006 returns 0x0100.
REQ-036 Dirty line at index 1 (tag 0), READ 0x0024 -> WB0/WB1 write 0x0004/0x0006 with old data, then fill; resp at 7 cycles.
REQ-037 READ 0x0003 -> resp_err pulse one cycle after accept, no memory activity, req_ready stays high.
REQ-038 Assert rst_n low during FILL1 -> mem_wren=0, no resp_valid; next READ same address misses again.
REQ-039 With CACHE_CTRL_STATS_EN: miss then hit to 0x0004 -> miss_count=1, hit_count=1.
